wb_exc_unit: RTL and testbench
==============================

# wb_exc_unit

Write-back-stage exception/interrupt commit unit for the LoongArch pipeline. Holds the WB pipeline register, picks the highest-priority exception or interrupt for the instruction in WB, and produces the `wb_ex`/`ertn_flush` event stream consumed by the CSR block. Flushes younger stages and stalls intake until fetch confirms the redirect to `ex_entry`.

## Interface
- `ECODE_W`, 6: ecode width.
- `ESUB_W`, 9: esubcode width.
- `clk  in  1`: single clock.
- `resetn  in  1`: synchronous, active-low reset; the only reset.
- `ms_to_ws_valid  in  1`: MEM stage offers an instruction.
- `ws_allowin  out  1`: WB accepts it this cycle.
- `ms_pc  in  32`, `ms_vaddr  in  32`: instruction PC; memory address (valid for ALE).
- `ms_exc  in  5`: flags {ine, brk, sys, ale, adef} (bit 0 = adef).
- `ms_ertn  in  1`: instruction is ERTN.
- `has_int  in  1`: CSR-qualified interrupt pending (IS & LIE & IE).
- `refetch_ack  in  1`: fetch has taken the redirect PC.
- `wb_ex  out  1`, `wb_ecode  out  6`, `wb_esubcode  out  9`, `wb_pc  out  32`, `wb_vaddr  out  32`: exception report to CSR.
- `ertn_flush  out  1`: ERTN commit to CSR.
- `ws_flush  out  1`: kill all younger stages.
- `ws_commit  out  1`: WB instruction retires (regfile/CSR writes allowed).

## Operation
- WB register: `ws_valid`, pc, vaddr, exc, ertn. It loads on `ms_to_ws_valid && ws_allowin`. When `ws_allowin && !ms_to_ws_valid`, `ws_valid` clears.
- FSM has two states.
  - RUN: `ws_allowin` = 1.
  - WAIT_REFETCH: `ws_allowin` = 0 and `ws_valid` is forced to 0.
- Event fires when `ws_valid` and state is RUN. Priority, first match wins:
  - `has_int`: ecode 0x00, sub 0.
  - adef: ecode 0x08 (ADE), sub 0 (ADEF).
  - ine: ecode 0x0D.
  - sys: ecode 0x0B.
  - brk: ecode 0x0C.
  - ale: ecode 0x09.
  - ertn.
- `wb_ex` = any exception/interrupt matched. `ertn_flush` = ertn matched with no exception/interrupt. Never both high.
- `wb_pc` = ws pc. `wb_vaddr` = ws vaddr. Both are forwarded whenever `ws_valid`.
- `wb_esubcode` = 0 for all listed causes.
- `ws_flush` = `wb_ex | ertn_flush`.
- `ws_commit` = `ws_valid && RUN && !ws_flush`.
- A flush event moves RUN→WAIT_REFETCH. `refetch_ack` in WAIT_REFETCH moves it back to RUN. `refetch_ack` in RUN is ignored.
- Interrupt is sampled only against a valid WB instruction in RUN. The interrupted instruction does not commit; ERA = its pc.

## Timing
- `wb_ex`, `ertn_flush`, `ws_flush` are combinational from WB register + state. Each is a one-cycle pulse, because state leaves RUN on the next edge.
- CSR sees the event in cycle N and updates on edge N+1. Fetch redirect happens ≥1 cycle later.
- Latency: MEM handshake at edge E → event visible in cycle after E.
- Earliest return: `refetch_ack` arriving the cycle after the flush gives RUN at the next edge; a new instruction can be accepted in that same RUN cycle.
- Offers from MEM during WAIT_REFETCH are not accepted (`ws_allowin` = 0). MEM must drop them on `ws_flush`.
- Reset (resetn=0 at edge) applies regardless of state. Values after reset:
  - state = RUN, `ws_valid` = 0.
  - `ws_allowin` = 1.
  - `wb_ex`, `ertn_flush`, `ws_flush`, `ws_commit` = 0.
  - `wb_ecode`/`wb_esubcode` = 0; `wb_pc`/`wb_vaddr` = 0.

## Structure
- Shared package/header (`constants.h`): ECODE_INT/ADE/ALE/SYS/BRK/INE, ESUBCODE_ADEF, and `ms_exc` bit indices. The CSR block uses the same names.
- One sub-module, `exc_prio_enc`: combinational priority encoder from {has_int, exc, ertn} to {ex, ertn, ecode, esubcode}.
- The FSM and WB register stay in the top.

## Test plan
- Plain retire: pc=0x1c000000, exc=0, ertn=0 → `ws_commit`=1 one cycle; no `wb_ex`; `ws_allowin` stays 1.
- SYS: exc=0b00100, pc=0x1c000010 → `wb_ex`=1, ecode=0x0B, `wb_pc`=0x1c000010, `ws_flush`=1 for exactly one cycle. `ws_allowin`=0 until `refetch_ack` is pulsed 3 cycles later, then 1 on the following cycle.
- Priority: exc=0b11111 with has_int=0 → ecode 0x08, sub 0. Same with has_int=1 → ecode 0x00. adef=0, ine=0, sys=1, ale=1 → 0x0B.
- ALE: exc=0b00010, vaddr=0x80000003 → ecode 0x09, `wb_vaddr`=0x80000003, `ws_commit`=0.
- ERTN: ertn=1, exc=0 → `ertn_flush`=1, `wb_ex`=0. ertn=1, exc=brk → `wb_ex`=1 (ecode 0x0C), `ertn_flush`=0.
- Reset during WAIT_REFETCH: resetn=0 for one edge → RUN, `ws_valid`=0, all outputs 0, `ws_allowin`=1. A stray `refetch_ack` afterwards has no effect.

Source files
------------

// File: rtl/wb_exc_unit_pkg.sv
// Shared exception codes, ms_exc bit layout and WB state encoding.
// Same names are used by the CSR block.
package wb_exc_unit_pkg;

    localparam int ECODE_W_DEF = 6;
    localparam int ESUB_W_DEF  = 9;

    localparam logic [5:0] ECODE_INT = 6'h00;
    localparam logic [5:0] ECODE_ADE = 6'h08;
    localparam logic [5:0] ECODE_ALE = 6'h09;
    localparam logic [5:0] ECODE_SYS = 6'h0B;
    localparam logic [5:0] ECODE_BRK = 6'h0C;
    localparam logic [5:0] ECODE_INE = 6'h0D;

    localparam logic [8:0] ESUBCODE_ADEF = 9'd0;

    localparam int EXC_ADEF = 0;
    localparam int EXC_ALE  = 1;
    localparam int EXC_SYS  = 2;
    localparam int EXC_BRK  = 3;
    localparam int EXC_INE  = 4;

    typedef enum logic {
        S_RUN,
        S_WAIT_REFETCH
    } ws_state_t;

endpackage

// File: rtl/wb_exc_unit_exc_prio_enc.sv
// Priority encoder: interrupt and exception flags of the WB instruction
// to a single report (exception with codes, or ERTN).
module exc_prio_enc
    import wb_exc_unit_pkg::*;
#(
    parameter int ECODE_W = ECODE_W_DEF,
    parameter int ESUB_W  = ESUB_W_DEF
) (
    input  logic               has_int,
    input  logic [4:0]         exc,
    input  logic               ertn,
    output logic               ex,
    output logic               ertn_hit,
    output logic [ECODE_W-1:0] ecode,
    output logic [ESUB_W-1:0]  esubcode
);

    always_comb begin
        ex       = 1'b1;
        ertn_hit = 1'b0;
        ecode    = '0;
        esubcode = '0;
        priority case (1'b1)
            has_int:        ecode = ECODE_W'(ECODE_INT);
            exc[EXC_ADEF]: begin
                ecode    = ECODE_W'(ECODE_ADE);
                esubcode = ESUB_W'(ESUBCODE_ADEF);
            end
            exc[EXC_INE]:   ecode = ECODE_W'(ECODE_INE);
            exc[EXC_SYS]:   ecode = ECODE_W'(ECODE_SYS);
            exc[EXC_BRK]:   ecode = ECODE_W'(ECODE_BRK);
            exc[EXC_ALE]:   ecode = ECODE_W'(ECODE_ALE);
            ertn: begin
                ex       = 1'b0;
                ertn_hit = 1'b1;
            end
            default:        ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/wb_exc_unit.sv
// WB pipeline register plus exception/ERTN commit; holds intake closed
// after a flush until fetch acknowledges the redirect.
module wb_exc_unit
    import wb_exc_unit_pkg::*;
#(
    parameter int ECODE_W = ECODE_W_DEF,
    parameter int ESUB_W  = ESUB_W_DEF
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               ms_to_ws_valid,
    output logic               ws_allowin,
    input  logic [31:0]        ms_pc,
    input  logic [31:0]        ms_vaddr,
    input  logic [4:0]         ms_exc,
    input  logic               ms_ertn,
    input  logic               has_int,
    input  logic               refetch_ack,
    output logic               wb_ex,
    output logic [ECODE_W-1:0] wb_ecode,
    output logic [ESUB_W-1:0]  wb_esubcode,
    output logic [31:0]        wb_pc,
    output logic [31:0]        wb_vaddr,
    output logic               ertn_flush,
    output logic               ws_flush,
    output logic               ws_commit
);

    ws_state_t state;
    ws_state_t state_nx;

    logic        ws_valid;
    logic [31:0] ws_pc;
    logic [31:0] ws_vaddr;
    logic [4:0]  ws_exc;
    logic        ws_ertn;

    logic               enc_ex;
    logic               enc_ertn;
    logic [ECODE_W-1:0] enc_ecode;
    logic [ESUB_W-1:0]  enc_esub;
    logic               fire;

    exc_prio_enc #(
        .ECODE_W (ECODE_W),
        .ESUB_W  (ESUB_W)
    ) u_prio (
        .has_int  (has_int),
        .exc      (ws_exc),
        .ertn     (ws_ertn),
        .ex       (enc_ex),
        .ertn_hit (enc_ertn),
        .ecode    (enc_ecode),
        .esubcode (enc_esub)
    );

    assign fire        = ws_valid && (state == S_RUN);
    assign wb_ex       = fire && enc_ex;
    assign ertn_flush  = fire && enc_ertn;
    assign ws_flush    = wb_ex || ertn_flush;
    assign ws_commit   = fire && !ws_flush;
    assign wb_ecode    = wb_ex ? enc_ecode : '0;
    assign wb_esubcode = wb_ex ? enc_esub : '0;
    assign wb_pc       = ws_valid ? ws_pc : '0;
    assign wb_vaddr    = ws_valid ? ws_vaddr : '0;
    assign ws_allowin  = (state == S_RUN);

    always_comb begin
        state_nx = state;
        unique case (state)
            S_RUN:          if (ws_flush) state_nx = S_WAIT_REFETCH;
            S_WAIT_REFETCH: if (refetch_ack) state_nx = S_RUN;
            default:        state_nx = S_RUN;
        endcase
    end

    // An offer coinciding with the flush belongs to the killed path.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= S_RUN;
            ws_valid <= 1'b0;
            ws_pc    <= '0;
            ws_vaddr <= '0;
            ws_exc   <= '0;
            ws_ertn  <= 1'b0;
        end else begin
            state <= state_nx;
            if (ws_flush || state != S_RUN) begin
                ws_valid <= 1'b0;
            end else begin
                ws_valid <= ms_to_ws_valid;
            end
            if (ms_to_ws_valid && ws_allowin && !ws_flush) begin
                ws_pc    <= ms_pc;
                ws_vaddr <= ms_vaddr;
                ws_exc   <= ms_exc;
                ws_ertn  <= ms_ertn;
            end
        end
    end

endmodule

// File: tb/tb_wb_exc_unit.sv
// Scoreboard bench for wb_exc_unit: directed cases then random traffic
// against a priority-table reference model.
module tb_wb_exc_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ms_to_ws_valid;
    logic        ws_allowin;
    logic [31:0] ms_pc;
    logic [31:0] ms_vaddr;
    logic [4:0]  ms_exc;
    logic        ms_ertn;
    logic        has_int;
    logic        refetch_ack;
    logic        wb_ex;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc;
    logic [31:0] wb_vaddr;
    logic        ertn_flush;
    logic        ws_flush;
    logic        ws_commit;

    always #5 clk = ~clk;

    wb_exc_unit dut (
        .clk            (clk),
        .resetn         (resetn),
        .ms_to_ws_valid (ms_to_ws_valid),
        .ws_allowin     (ws_allowin),
        .ms_pc          (ms_pc),
        .ms_vaddr       (ms_vaddr),
        .ms_exc         (ms_exc),
        .ms_ertn        (ms_ertn),
        .has_int        (has_int),
        .refetch_ack    (refetch_ack),
        .wb_ex          (wb_ex),
        .wb_ecode       (wb_ecode),
        .wb_esubcode    (wb_esubcode),
        .wb_pc          (wb_pc),
        .wb_vaddr       (wb_vaddr),
        .ertn_flush     (ertn_flush),
        .ws_flush       (ws_flush),
        .ws_commit      (ws_commit)
    );

    // kind: 0 = retire, 1 = exception/interrupt, 2 = ertn
    typedef struct {
        int          kind;
        logic [5:0]  ecode;
        logic [31:0] pc;
        logic [31:0] vaddr;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    function automatic void chk(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got === want) passes++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
    endfunction

    // Causes in descending priority: {flag position in ms_exc, ecode}.
    int          prio_bit[5]  = '{0, 4, 2, 3, 1};
    logic [5:0]  prio_code[5] = '{6'h08, 6'h0D, 6'h0B, 6'h0C, 6'h09};

    function automatic exp_t model(logic [31:0] pc, logic [31:0] va,
                                   logic [4:0] exc, logic er, logic intr);
        exp_t e;
        e.pc    = pc;
        e.vaddr = va;
        e.kind  = 0;
        e.ecode = 6'h00;
        if (intr) begin
            e.kind = 1;
            return e;
        end
        for (int i = 0; i < 5; i++) begin
            if (exc[prio_bit[i]]) begin
                e.kind  = 1;
                e.ecode = prio_code[i];
                return e;
            end
        end
        if (er) e.kind = 2;
        return e;
    endfunction

    always @(negedge clk) begin
        if (resetn && (ws_commit || ws_flush)) begin
            exp_t e;
            int   got_kind;
            got_kind = wb_ex ? 1 : (ertn_flush ? 2 : 0);
            chk("ex_ertn_exclusive", 32'(wb_ex && ertn_flush), 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_event", 32'(got_kind), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("kind", 32'(got_kind), 32'(e.kind));
                chk("ecode", 32'(wb_ecode), 32'(e.ecode));
                chk("esubcode", 32'(wb_esubcode), 32'd0);
                chk("wb_pc", wb_pc, e.pc);
                chk("wb_vaddr", wb_vaddr, e.vaddr);
            end
        end
    end

    task automatic issue(input logic [31:0] pc, input logic [31:0] va,
                         input logic [4:0] exc, input logic er,
                         input logic intr, input int ack_gap);
        exp_t e;
        e = model(pc, va, exc, er, intr);
        @(posedge clk); #1;
        ms_to_ws_valid = 1'b1;
        ms_pc          = pc;
        ms_vaddr       = va;
        ms_exc         = exc;
        ms_ertn        = er;
        has_int        = 1'($urandom_range(0, 1));
        sb.push_back(e);
        @(posedge clk); #1;
        ms_to_ws_valid = 1'b0;
        has_int        = intr;
        @(posedge clk); #1;
        has_int = 1'b0;
        if (e.kind != 0) begin
            for (int i = 0; i < ack_gap; i++) begin
                chk("allowin_wait", 32'(ws_allowin), 32'd0);
                chk("no_commit_wait", 32'(ws_commit), 32'd0);
                @(posedge clk); #1;
            end
            refetch_ack = 1'b1;
            @(posedge clk); #1;
            refetch_ack = 1'b0;
            chk("allowin_back", 32'(ws_allowin), 32'd1);
        end else begin
            chk("allowin_run", 32'(ws_allowin), 32'd1);
        end
    endtask

    task automatic stream(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            ms_to_ws_valid = 1'b1;
            ms_pc          = 32'h1c00_1000 + 32'(i * 4);
            ms_vaddr       = $urandom;
            ms_exc         = 5'b0;
            ms_ertn        = 1'b0;
            has_int        = 1'b0;
            sb.push_back(model(ms_pc, ms_vaddr, 5'b0, 1'b0, 1'b0));
        end
        @(posedge clk); #1;
        ms_to_ws_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic check_idle(string tag);
        chk({tag, "_allowin"}, 32'(ws_allowin), 32'd1);
        chk({tag, "_wb_ex"}, 32'(wb_ex), 32'd0);
        chk({tag, "_ertn_flush"}, 32'(ertn_flush), 32'd0);
        chk({tag, "_ws_flush"}, 32'(ws_flush), 32'd0);
        chk({tag, "_ws_commit"}, 32'(ws_commit), 32'd0);
        chk({tag, "_ecode"}, 32'(wb_ecode), 32'd0);
        chk({tag, "_esub"}, 32'(wb_esubcode), 32'd0);
        chk({tag, "_pc"}, wb_pc, 32'd0);
        chk({tag, "_vaddr"}, wb_vaddr, 32'd0);
    endtask

    initial begin
        resetn         = 1'b0;
        ms_to_ws_valid = 1'b0;
        ms_pc          = '0;
        ms_vaddr       = '0;
        ms_exc         = '0;
        ms_ertn        = 1'b0;
        has_int        = 1'b0;
        refetch_ack    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        check_idle("reset");

        issue(32'h1c00_0000, 32'h0, 5'b00000, 1'b0, 1'b0, 0);
        issue(32'h1c00_0010, 32'h0, 5'b00100, 1'b0, 1'b0, 2);
        issue(32'h1c00_0020, 32'h1, 5'b11111, 1'b0, 1'b0, 0);
        issue(32'h1c00_0030, 32'h2, 5'b11111, 1'b0, 1'b1, 1);
        issue(32'h1c00_0040, 32'h3, 5'b00110, 1'b0, 1'b0, 0);
        issue(32'h1c00_0050, 32'h8000_0003, 5'b00010, 1'b0, 1'b0, 1);
        issue(32'h1c00_0060, 32'h0, 5'b00000, 1'b1, 1'b0, 0);
        issue(32'h1c00_0070, 32'h0, 5'b01000, 1'b1, 1'b0, 3);
        stream(6);

        // Reset taken while waiting for the refetch acknowledge.
        @(posedge clk); #1;
        ms_to_ws_valid = 1'b1;
        ms_pc          = 32'h1c00_0200;
        ms_vaddr       = 32'h0;
        ms_exc         = 5'b00100;
        ms_ertn        = 1'b0;
        sb.push_back(model(32'h1c00_0200, 32'h0, 5'b00100, 1'b0, 1'b0));
        @(posedge clk); #1;
        ms_to_ws_valid = 1'b0;
        @(posedge clk); #1;
        chk("wait_before_reset", 32'(ws_allowin), 32'd0);
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        check_idle("reset_in_wait");
        refetch_ack = 1'b1;
        @(posedge clk); #1;
        refetch_ack = 1'b0;
        chk("stray_ack_allowin", 32'(ws_allowin), 32'd1);
        chk("stray_ack_commit", 32'(ws_commit), 32'd0);
        issue(32'h1c00_0300, 32'h0, 5'b00000, 1'b0, 1'b0, 0);

        for (int n = 0; n < 150; n++) begin
            logic [4:0] exc;
            exc = ($urandom_range(0, 1) == 0) ? 5'b0 : 5'($urandom);
            issue({$urandom} & 32'hFFFF_FFFC, $urandom, exc,
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 6) == 0),
                  int'($urandom_range(0, 4)));
            if ($urandom_range(0, 9) == 0) stream(int'($urandom_range(1, 4)));
        end

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
